// File: rtl/car_motion_ctrl.sv
// ---------------------------------------------------------------------------
// car_motion_ctrl
//   Frame-synchronous motion scheduler for the player car sprite.
//   Debounces the left/right buttons once per frame and runs an
//   IDLE/ACCEL/CRUISE/BRAKE FSM. Every state change happens on a clk edge
//   with frame_tick=1, so car_x stays constant for the renderer between ticks.
//
//   Per tick:
//     1) position moves by the speed held *before* this tick
//     2) FSM/speed update, which sees the debounced buttons held before this tick
//     3) debounce update
//
//   Build option: define WRAP_AROUND_EN to wrap car_x around the screen
//   instead of clamping (no bump, speed preserved).
//
// Ports
//   clk        in   pixel clock
//   rst_n      in   synchronous reset, active-low
//   frame_tick in   1-cycle pulse, once per frame
//   btn_left   in   raw left button
//   btn_right  in   raw right button
//   car_x      out  [9:0] car left-edge X position
//   speed      out  [2:0] current speed, pixels/frame
//   dir        out  0 = right, 1 = left
//   moving     out  speed != 0
//   bump       out  1-cycle pulse when the car is clamped at a screen edge
// ---------------------------------------------------------------------------

// One debounced button. The output flips only after DEBOUNCE_FRAMES
// consecutive tick samples that disagree with it.
module car_btn_debounce #(
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_tick,
    input  logic btn,
    output logic db
);
    localparam int CNT_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (frame_tick) begin
            if (btn == db) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
                db  <= btn;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module car_motion_ctrl #(
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 600,
    parameter int X_RESET         = 100,
    parameter int MAX_SPEED       = 3,
    parameter int ACCEL_FRAMES    = 4,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [9:0] car_x,
    output logic [2:0] speed,
    output logic       dir,
    output logic       moving,
    output logic       bump
);
    localparam int ACNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        BRAKE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ACNT_W-1:0] acnt_q, acnt_d;
    logic [9:0]        car_x_d;
    logic [2:0]        speed_d;
    logic              dir_d, bump_d;

    // ---- debounce: index 0 = right, 1 = left ----
    logic [1:0] btn_raw, db;
    assign btn_raw = {btn_left, btn_right};

    for (genvar i = 0; i < 2; i++) begin : g_db
        car_btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db (
            .clk        (clk),
            .rst_n      (rst_n),
            .frame_tick (frame_tick),
            .btn        (btn_raw[i]),
            .db         (db[i])
        );
    end

    // Both or neither pressed means no request.
    logic req_r, req_l, req_any, req_same;
    assign req_r    = db[0] & ~db[1];
    assign req_l    = db[1] & ~db[0];
    assign req_any  = req_r | req_l;
    assign req_same = dir ? req_l : req_r;

    // ---- position datapath (11 bits so overflow past X_MAX is visible) ----
    logic [10:0] x_ext, spd_ext, sum_r, diff_l, pos_n;
    logic        ovf_r, ovf_l;

    assign x_ext   = {1'b0, car_x};
    assign spd_ext = {8'b0, speed};
    assign sum_r   = x_ext + spd_ext;
    assign diff_l  = x_ext - spd_ext;
    assign ovf_r   = !dir && (sum_r > 11'(X_MAX));
    assign ovf_l   =  dir && (x_ext < 11'(X_MIN) + spd_ext);

    always_comb begin
        pos_n = dir ? diff_l : sum_r;
`ifdef WRAP_AROUND_EN
        // Wrap: overshoot past one edge re-enters from the other edge.
        if (ovf_r)
            pos_n = 11'(X_MIN) + (sum_r - 11'(X_MAX) - 11'd1);
        else if (ovf_l)
            pos_n = 11'(X_MAX - X_MIN + 1) + x_ext - spd_ext;
`else
        if (ovf_r)
            pos_n = 11'(X_MAX);
        else if (ovf_l)
            pos_n = 11'(X_MIN);
`endif
    end

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acnt_q  <= '0;
            car_x   <= 10'(X_RESET);
            speed   <= 3'd0;
            dir     <= 1'b0;
            moving  <= 1'b0;
            bump    <= 1'b0;
        end else begin
            state_q <= state_d;
            acnt_q  <= acnt_d;
            car_x   <= car_x_d;
            speed   <= speed_d;
            dir     <= dir_d;
            moving  <= (speed_d != 3'd0);
            bump    <= bump_d;
        end
    end

    // ---- next state / outputs ----
    logic [2:0] spd_inc, spd_dec;
    assign spd_inc = speed + 3'd1;
    assign spd_dec = (speed == 3'd0) ? 3'd0 : speed - 3'd1;

    always_comb begin
        state_d = state_q;
        acnt_d  = acnt_q;
        car_x_d = car_x;
        speed_d = speed;
        dir_d   = dir;
        bump_d  = 1'b0;

        if (frame_tick) begin
            car_x_d = pos_n[9:0];

            unique case (state_q)
                IDLE: begin
                    if (req_any) begin
                        dir_d   = req_l;
                        speed_d = 3'd1;
                        acnt_d  = '0;
                        state_d = (MAX_SPEED == 1) ? CRUISE : ACCEL;
                    end
                end
                ACCEL: begin
                    if (!req_same) begin
                        // Braking starts on the tick the request drops.
                        speed_d = spd_dec;
                        acnt_d  = '0;
                        state_d = (spd_dec == 3'd0) ? IDLE : BRAKE;
                    end else if (acnt_q == ACNT_W'(ACCEL_FRAMES - 1)) begin
                        speed_d = spd_inc;
                        acnt_d  = '0;
                        if (spd_inc == 3'(MAX_SPEED))
                            state_d = CRUISE;
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
                CRUISE: begin
                    if (!req_same) begin
                        speed_d = spd_dec;
                        acnt_d  = '0;
                        state_d = (spd_dec == 3'd0) ? IDLE : BRAKE;
                    end
                end
                BRAKE: begin
                    if (req_same && speed != 3'd0) begin
                        acnt_d  = '0;
                        state_d = ACCEL;
                    end else begin
                        // Opposite request keeps braking; reversal is
                        // picked up from IDLE on a later tick.
                        speed_d = spd_dec;
                        state_d = (spd_dec == 3'd0) ? IDLE : BRAKE;
                    end
                end
                default: state_d = IDLE;
            endcase

`ifndef WRAP_AROUND_EN
            // Hitting an edge overrides whatever the FSM decided this tick.
            if (ovf_r || ovf_l) begin
                bump_d  = 1'b1;
                speed_d = 3'd0;
                acnt_d  = '0;
                state_d = IDLE;
            end
`endif
        end
    end
endmodule
